// File: rtl/vga_timing_pkg.sv
// Shared widths, default 1280x1024@60 timing set and the 12-bit colour payload
// used by the raster timing generator.
package vga_timing_pkg;

  localparam int unsigned X_W   = 12;
  localparam int unsigned Y_W   = 11;
  localparam int unsigned RGB_W = 12;

  localparam int unsigned H_ACTIVE_DEF = 1280;
  localparam int unsigned H_FP_DEF     = 48;
  localparam int unsigned H_SYNC_DEF   = 112;
  localparam int unsigned H_BP_DEF     = 248;
  localparam int unsigned V_ACTIVE_DEF = 1024;
  localparam int unsigned V_FP_DEF     = 1;
  localparam int unsigned V_SYNC_DEF   = 3;
  localparam int unsigned V_BP_DEF     = 38;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

endpackage

// File: rtl/vga_timing_if.sv
// Raster bus: pixel coordinates out to the map stage, map colour back, VGA pins out.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           active;
  logic           frame_start;
  rgb12_t         map_rgb;
  logic [3:0]     vga_r;
  logic [3:0]     vga_g;
  logic [3:0]     vga_b;
  logic           vga_hs;
  logic           vga_vs;
  logic           vga_blank_n;

  modport master (
    output x, y, active, frame_start,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
    input  map_rgb
  );

  modport slave (
    input  x, y, active, frame_start,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
    output map_rgb
  );

endinterface

// File: rtl/sync_delay.sv
// Clock-enabled shift register with async clear; DEPTH=0 degenerates to a wire.
module sync_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < int'(DEPTH); i++) sr[i] <= '0;
      end else if (en) begin
        sr[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing.sv
// Raster counters, sync decode and output aligner around a registered map lookup;
// syncs and blank are delayed to land with the map colour on the VGA pins.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter bit          SYNC_POS    = 1'b1,
  parameter int unsigned MAP_LATENCY = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         pix_en,
  vga_timing_if.master vif
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END    = HS_START + H_SYNC;
  localparam int unsigned VS_START  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END    = VS_START + V_SYNC;

  if (H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_size_err
    $error("vga_timing: H_TOTAL/V_TOTAL exceed counter width");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_porch_err
    $error("vga_timing: porch and sync widths must be at least 1");
  end

  logic [X_W-1:0] h;
  logic [Y_W-1:0] v;
  logic           h_last;
  logic           v_last;
  logic           hs_raw;
  logic           vs_raw;
  logic           act_raw;
  logic           hs_d;
  logic           vs_d;
  logic           act_d;
  rgb12_t         rgb_q;
  logic           blank_n_q;
  logic           hs_q;
  logic           vs_q;

  assign h_last = (h == X_W'(H_TOTAL - 1));
  assign v_last = (v == Y_W'(V_TOTAL - 1));

  // Pixel/line counters; v steps only on h wrap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + Y_W'(1);
      end else begin
        h <= h + X_W'(1);
      end
    end
  end

  assign hs_raw  = (h >= X_W'(HS_START)) && (h < X_W'(HS_END));
  assign vs_raw  = (v >= Y_W'(VS_START)) && (v < Y_W'(VS_END));
  assign act_raw = (h < X_W'(H_ACTIVE)) && (v < Y_W'(V_ACTIVE));

  // Match the map read latency so syncs/blank line up with map_rgb.
  sync_delay #(
    .WIDTH (3),
    .DEPTH (MAP_LATENCY)
  ) u_sync_delay (
    .clock  (clock),
    .resetn (resetn),
    .en     (pix_en),
    .d      ({hs_raw, vs_raw, act_raw}),
    .q      ({hs_d, vs_d, act_d})
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rgb_q     <= '0;
      blank_n_q <= 1'b0;
      hs_q      <= ~SYNC_POS;
      vs_q      <= ~SYNC_POS;
    end else if (pix_en) begin
      rgb_q     <= act_d ? vif.map_rgb : '0;
      blank_n_q <= act_d;
      hs_q      <= hs_d ~^ SYNC_POS;
      vs_q      <= vs_d ~^ SYNC_POS;
    end
  end

  assign vif.x           = h;
  assign vif.y           = v;
  assign vif.active      = act_raw;
  assign vif.frame_start = (h == '0) && (v == '0);
  assign vif.vga_r       = rgb_q.r;
  assign vif.vga_g       = rgb_q.g;
  assign vif.vga_b       = rgb_q.b;
  assign vif.vga_hs      = hs_q;
  assign vif.vga_vs      = vs_q;
  assign vif.vga_blank_n = blank_n_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboarded bench for vga_timing on a reduced raster with a 1-cycle map RAM model.
module tb_vga_timing;
  import vga_timing_pkg::*;

  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 4;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int ML = 1;
  localparam bit SP = 1'b1;

  typedef struct packed {
    logic [11:0] rgb;
    logic        blank_n;
    logic        hs;
    logic        vs;
  } out_t;

  logic clock;
  logic resetn;
  logic pix_en;

  vga_timing_if vif ();

  vga_timing #(
    .H_ACTIVE    (HA),
    .H_FP        (HF),
    .H_SYNC      (HS),
    .H_BP        (HB),
    .V_ACTIVE    (VA),
    .V_FP        (VF),
    .V_SYNC      (VS),
    .V_BP        (VB),
    .SYNC_POS    (SP),
    .MAP_LATENCY (ML)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .pix_en (pix_en),
    .vif    (vif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Map stage: registered read returning {x[3:0], y[3:0], 5}.
  always @(posedge clock) begin
    if (pix_en) vif.map_rgb <= rgb12_t'({vif.x[3:0], vif.y[3:0], 4'h5});
  end

  int   n_assert = 0;
  int   n_fail   = 0;
  int   mh, mv;
  out_t exp_o;
  out_t sb[$];
  out_t rst_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (x=%0d y=%0d)", tag, obs, exp, mh, mv);
    end
  endtask

  function automatic out_t pix_out(input int h, input int v);
    out_t        o;
    logic [31:0] hv, vv;
    logic        act, hr, vr;
    hv  = h;
    vv  = v;
    act = (h < HA) && (v < VA);
    hr  = (h >= HA + HF) && (h < HA + HF + HS);
    vr  = (v >= VA + VF) && (v < VA + VF + VS);
    o.rgb     = act ? {hv[3:0], vv[3:0], 4'h5} : 12'h000;
    o.blank_n = act;
    o.hs      = hr ? SP : ~SP;
    o.vs      = vr ? SP : ~SP;
    return o;
  endfunction

  task automatic model_reset();
    mh = 0;
    mv = 0;
    sb.delete();
    for (int i = 0; i < ML; i++) sb.push_back(rst_o);
    exp_o = rst_o;
  endtask

  task automatic check_all();
    chk("x", 32'(vif.x), 32'(mh));
    chk("y", 32'(vif.y), 32'(mv));
    chk("active", 32'(vif.active), 32'((mh < HA) && (mv < VA)));
    chk("frame_start", 32'(vif.frame_start), 32'((mh == 0) && (mv == 0)));
    chk("rgb", 32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'(exp_o.rgb));
    chk("blank_n", 32'(vif.vga_blank_n), 32'(exp_o.blank_n));
    chk("hs", 32'(vif.vga_hs), 32'(exp_o.hs));
    chk("vs", 32'(vif.vga_vs), 32'(exp_o.vs));
  endtask

  task automatic step(input bit en);
    pix_en = en;
    @(posedge clock);
    if (en) begin
      exp_o = sb.pop_front();
      sb.push_back(pix_out(mh, mv));
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    #1;
    check_all();
  endtask

  int   t_since_x0;
  int   hs_run;
  int   cnt_blank, cnt_hs, cnt_vs;
  logic prev_hs, prev_vs;
  bit   found;

  initial begin
    rst_o.rgb     = 12'h000;
    rst_o.blank_n = 1'b0;
    rst_o.hs      = ~SP;
    rst_o.vs      = ~SP;
    resetn = 1'b0;
    pix_en = 1'b0;
    model_reset();

    // Reset held: coordinates at origin, pins idle.
    #3;
    check_all();
    @(posedge clock);
    #1;
    check_all();
    @(posedge clock);
    #3;
    resetn = 1'b1;
    #1;

    // Two full frames enabled; totals measured over the second.
    t_since_x0 = 0;
    hs_run     = 0;
    cnt_blank  = 0;
    cnt_hs     = 0;
    cnt_vs     = 0;
    prev_hs    = vif.vga_hs;
    prev_vs    = vif.vga_vs;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b1);
      t_since_x0 = (vif.x == '0) ? 0 : t_since_x0 + 1;
      if (vif.vga_hs === SP && prev_hs !== SP) chk("hs_lead", 32'(t_since_x0), 32'(HA + HF + ML + 1));
      if (vif.vga_hs === SP) hs_run++;
      else begin
        if (prev_hs === SP) chk("hs_width", 32'(hs_run), 32'(HS));
        hs_run = 0;
      end
      if (vif.vga_vs === SP && prev_vs !== SP) begin
        chk("vs_start_y", 32'(vif.y), 32'(VA + VF));
        chk("vs_start_x", 32'(vif.x), 32'(ML + 1));
      end
      if (i >= FRAME) begin
        if (vif.vga_blank_n === 1'b1) cnt_blank++;
        if (vif.vga_hs === SP) cnt_hs++;
        if (vif.vga_vs === SP) cnt_vs++;
      end
      prev_hs = vif.vga_hs;
      prev_vs = vif.vga_vs;
    end
    chk("blank_total", 32'(cnt_blank), 32'(HA * VA));
    chk("hs_total", 32'(cnt_hs), 32'(HS * VT));
    chk("vs_total", 32'(cnt_vs), 32'(VS * HT));

    // Pseudo-random enable: same pixel stream, holds when disabled.
    for (int i = 0; i < 600; i++) step(1'(($urandom_range(0, 1))));

    // Run to a mid-frame point, then pulse reset asynchronously.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step(1'b1);
      if (mh == 10 && mv == 3) found = 1'b1;
    end
    chk("reach_midframe", 32'(found), 32'(1));
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clock);
    #1;
    check_all();
    @(posedge clock);
    #3;
    resetn = 1'b1;
    for (int i = 0; i < 3 * HT; i++) step(1'(($urandom_range(0, 3) != 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
